// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: TileLink opcodes, access sizes and FSM states shared by the memory-access stage.
package mem_access_unit_pkg;
  localparam logic [2:0] TL_GET         = 3'd4;
  localparam logic [2:0] TL_PUT_FULL    = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] TL_ACK         = 3'd0;
  localparam logic [2:0] TL_ACK_DATA    = 3'd1;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} sz_e;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP, ST_DONE} st_e;
  function automatic logic misaligned(logic [1:0] s, logic [2:0] a);
    return s == SZ_H ? a[0] : s == SZ_W ? |a[1:0] : s == SZ_D ? |a : 1'b0;
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane mask and store replication, plus load extraction and sign/zero extension.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [2:0]  offset,
  input  logic [63:0] st_data,
  input  logic [63:0] ld_data,
  input  logic        ld_unsigned,
  output logic [7:0]  mask,
  output logic [63:0] st_lanes,
  output logic [63:0] ld_result
);
  logic [63:0] sh;
  always_comb begin
    mask = (size == SZ_B ? 8'h01 : size == SZ_H ? 8'h03 : size == SZ_W ? 8'h0f : 8'hff) << offset;
    st_lanes = size == SZ_B ? {8{st_data[7:0]}} :
               size == SZ_H ? {4{st_data[15:0]}} :
               size == SZ_W ? {2{st_data[31:0]}} : st_data;
    sh = ld_data >> {offset, 3'b000};
    ld_result = size == SZ_B ? {{56{~ld_unsigned & sh[7]}}, sh[7:0]} :
                size == SZ_H ? {{48{~ld_unsigned & sh[15]}}, sh[15:0]} :
                size == SZ_W ? {{32{~ld_unsigned & sh[31]}}, sh[31:0]} : sh;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: RV64 memory stage, single-outstanding TileLink-UL master with writeback pass-through.
// Define MEM_ACCESS_TIMEOUT_EN to enable the D-channel watchdog (TIMEOUT_CYCLES).
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_data,
  input  logic            in_load,
  input  logic            in_store,
  input  logic [1:0]      in_size,
  input  logic            in_unsigned,
  output logic            stall,
  output logic            request,
  output logic            a_valid,
  input  logic            a_ready,
  output logic [2:0]      a_opcode,
  output logic [2:0]      a_size,
  output logic [XLEN-1:0] a_address,
  output logic [7:0]      a_mask,
  output logic [XLEN-1:0] a_data,
  input  logic            d_valid,
  output logic            d_ready,
  input  logic [2:0]      d_opcode,
  input  logic [1:0]      d_param,
  input  logic            d_denied,
  input  logic [XLEN-1:0] d_data,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_pc,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_fault,
  output logic            wb_misaligned
);
  st_e state, state_n;
  logic [XLEN-1:0] pc_q, addr_q, data_q;
  logic [4:0] rd_q;
  logic [1:0] size_q;
  logic load_q, uns_q;
  logic [7:0] mask;
  logic [63:0] st_lanes, ld_result;
  logic accept, is_mem, mis, d_bad, tmo, resp_end, fault;
  logic unused;
  assign unused = ^{d_param, TIMEOUT_CYCLES[0]};
  assign accept = in_valid && state == ST_IDLE;
  assign is_mem = in_load || in_store;
  assign mis = is_mem && misaligned(in_size, in_addr[2:0]);
  assign d_bad = d_denied || (load_q ? d_opcode != TL_ACK_DATA : d_opcode != TL_ACK);
  assign resp_end = state == ST_RESP && (d_valid || tmo);
  assign fault = tmo || d_bad;
`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= state != ST_RESP ? '0 : cnt + CW'(!d_valid);
  assign tmo = state == ST_RESP && !d_valid && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: state_n = accept && is_mem && !mis ? ST_REQ : ST_IDLE;
      ST_REQ:  state_n = a_ready ? ST_RESP : ST_REQ;
      ST_RESP: state_n = d_valid || tmo ? ST_DONE : ST_RESP;
      default: state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      rd_q <= '0;
      size_q <= '0;
      load_q <= 1'b0;
      uns_q <= 1'b0;
      wb_valid <= 1'b0;
      wb_pc <= '0;
      wb_rd <= '0;
      wb_data <= '0;
      wb_fault <= 1'b0;
      wb_misaligned <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if (accept) begin
        pc_q <= in_pc;
        addr_q <= in_addr;
        data_q <= in_data;
        rd_q <= in_rd;
        size_q <= in_size;
        load_q <= in_load;
        uns_q <= in_unsigned;
      end
      if (accept && (!is_mem || mis)) begin
        wb_valid <= 1'b1;
        wb_pc <= in_pc;
        wb_rd <= mis ? 5'd0 : in_rd;
        wb_data <= mis ? '0 : in_addr;
        wb_fault <= 1'b0;
        wb_misaligned <= mis;
      end else if (resp_end) begin
        wb_valid <= 1'b1;
        wb_pc <= pc_q;
        wb_rd <= load_q ? rd_q : 5'd0;
        wb_data <= load_q && !fault ? ld_result : '0;
        wb_fault <= fault;
        wb_misaligned <= 1'b0;
      end
    end
  mem_lane_align u_align (
    .size       (size_q),
    .offset     (addr_q[2:0]),
    .st_data    (data_q),
    .ld_data    (d_data),
    .ld_unsigned(uns_q),
    .mask       (mask),
    .st_lanes   (st_lanes),
    .ld_result  (ld_result)
  );
  // A-channel fields are gated so they read zero outside REQ (including under reset).
  assign in_ready = state == ST_IDLE;
  assign stall = state != ST_IDLE;
  assign request = state == ST_RESP;
  assign d_ready = state == ST_RESP;
  assign a_valid = state == ST_REQ;
  assign a_opcode = !a_valid ? 3'd0 : load_q ? TL_GET : size_q == SZ_D ? TL_PUT_FULL : TL_PUT_PARTIAL;
  assign a_size = a_valid ? {1'b0, size_q} : 3'd0;
  assign a_address = a_valid ? addr_q : '0;
  assign a_mask = a_valid ? mask : 8'd0;
  assign a_data = a_valid && !load_q ? st_lanes : '0;
endmodule
